// File: rtl/range_info_loader_pkg.sv
// rtl/range_info_loader_pkg.sv - shared constants, state encoding and width helpers for the range-info loader
package range_info_loader_pkg;

    // Error flag bit positions inside the sticky err bus
    localparam int ERR_LEN   = 0;
    localparam int ERR_POS   = 1;
    localparam int ERR_ORDER = 2;
    localparam int ERR_W     = 3;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    // Index of the highest set bit (0 for an input of 0)
    function automatic int msb_idx(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (value[i]) r = i;
        end
        return r;
    endfunction

    // Index of the active bit inside an entry; position bits sit below it
    function automatic int active_bit(input int word_max_len);
        return 1 + msb_idx(word_max_len - 1);
    endfunction

    // Entry width: position field plus the active bit
    function automatic int entry_width(input int word_max_len);
        return active_bit(word_max_len) + 1;
    endfunction

endpackage

// File: rtl/range_entry_check.sv
// rtl/range_entry_check.sv - combinational validator for one incoming range entry byte
module range_entry_check
    import range_info_loader_pkg::*;
#(
    parameter int WORD_MAX_LEN = 8,
    parameter int ENTRY_W      = entry_width(WORD_MAX_LEN)
) (
    input  logic [7:0]       din_i,
    input  logic             earlier_inactive_i,
    output logic [ERR_W-1:0] err_o
);

    localparam int ACT_BIT = ENTRY_W - 1;
    // Bits above the entry field must be zero in a legal byte
    localparam logic [7:0] UPPER_MASK = 8'(32'hFF << ENTRY_W);

    logic               active;
    logic [ACT_BIT-1:0] pos;

    assign active = din_i[ACT_BIT];
    assign pos    = din_i[ACT_BIT-1:0];

    // Length overflow depends on the slot count, so the loader owns that flag
    always_comb begin
        err_o            = '0;
        err_o[ERR_POS]   = (|(din_i & UPPER_MASK)) | (active & (int'(pos) >= WORD_MAX_LEN));
        err_o[ERR_ORDER] = active & earlier_inactive_i;
    end

endmodule

// File: rtl/range_info_loader.sv
// rtl/range_info_loader.sv - double-buffered loader of packed range_info from the pkt_comm byte stream
module range_info_loader
    import range_info_loader_pkg::*;
#(
    parameter int WORD_MAX_LEN   = 8,
    parameter int RANGES_MAX     = 8,
    parameter int RANGE_INFO_MSB = active_bit(WORD_MAX_LEN)
) (
    input  logic                                      CLK,
    input  logic                                      rst_n,
    input  logic [7:0]                                din,
    input  logic                                      wr_en,
    input  logic                                      pkt_end,
    output logic                                      full,
    input  logic                                      gen_idle,
    output logic [RANGES_MAX*(RANGE_INFO_MSB+1)-1:0]  range_info,
    output logic                                      range_info_new,
    output logic [ERR_W-1:0]                          err
);

    localparam int ENTRY_W = RANGE_INFO_MSB + 1;
    localparam int CNT_W   = (RANGES_MAX > 1) ? $clog2(RANGES_MAX) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RANGES_MAX - 1);

    state_e                                   state_q;
    logic [CNT_W-1:0]                         cnt_q;
    logic [RANGES_MAX-1:0][ENTRY_W-1:0]       shadow_q;
    logic                                     inactive_seen_q;
    logic [RANGES_MAX*ENTRY_W-1:0]            range_info_q;
    logic                                     range_info_new_q;
    logic [ERR_W-1:0]                         err_q;
    logic                                     full_q;

    logic                                     accept_d;
    logic [ERR_W-1:0]                         chk_err;
    logic [ERR_W-1:0]                         byte_err_d;

    range_entry_check #(
        .WORD_MAX_LEN (WORD_MAX_LEN),
        .ENTRY_W      (ENTRY_W)
    ) u_check (
        .din_i              (din),
        .earlier_inactive_i (inactive_seen_q),
        .err_o              (chk_err)
    );

    // Byte acceptance and the full set of error flags raised by this byte
    always_comb begin
        accept_d            = wr_en & ~full_q;
        byte_err_d          = chk_err;
        byte_err_d[ERR_LEN] = ~pkt_end & (cnt_q == LAST_SLOT);
    end

    // Loader FSM: fills the shadow, hands it over on gen_idle, parks in ERROR on any bad byte
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_LOAD;
            cnt_q            <= '0;
            shadow_q         <= '0;
            inactive_seen_q  <= 1'b0;
            range_info_q     <= '0;
            range_info_new_q <= 1'b0;
            err_q            <= '0;
            full_q           <= 1'b0;
        end else begin
            range_info_new_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (accept_d) begin
                        if (byte_err_d != '0) begin
                            err_q   <= err_q | byte_err_d;
                            state_q <= ST_ERROR;
                            full_q  <= 1'b1;
                        end else begin
                            shadow_q[cnt_q] <= din[ENTRY_W-1:0];
                            if (!din[ENTRY_W-1]) inactive_seen_q <= 1'b1;
                            if (pkt_end) begin
                                for (int i = 0; i < RANGES_MAX; i++) begin
                                    if (i > int'(cnt_q)) shadow_q[i] <= '0;
                                end
                                state_q <= ST_READY;
                                full_q  <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                end
                ST_READY: begin
                    if (gen_idle) begin
                        range_info_q     <= shadow_q;
                        range_info_new_q <= 1'b1;
                        cnt_q            <= '0;
                        shadow_q         <= '0;
                        inactive_seen_q  <= 1'b0;
                        state_q          <= ST_LOAD;
                        full_q           <= 1'b0;
                    end
                end
                default: begin
                    full_q <= 1'b1;
                end
            endcase
        end
    end

    assign full           = full_q;
    assign range_info     = range_info_q;
    assign range_info_new = range_info_new_q;
    assign err            = err_q;

endmodule

// File: tb/tb_range_info_loader.sv
// tb/tb_range_info_loader.sv - directed self-checking bench for range_info_loader
module tb_range_info_loader;

    logic        CLK;
    logic        rst_n, rst6_n;
    logic [7:0]  din, din6;
    logic        wr_en, wr_en6;
    logic        pkt_end, pkt_end6;
    logic        gen_idle, gen_idle6;
    logic        full, full6;
    logic [31:0] range_info, range_info6;
    logic        range_info_new, range_info_new6;
    logic [2:0]  err, err6;

    int vectors;
    int miscompares;

    range_info_loader #(.WORD_MAX_LEN(8), .RANGES_MAX(8)) u_dut (
        .CLK            (CLK),
        .rst_n          (rst_n),
        .din            (din),
        .wr_en          (wr_en),
        .pkt_end        (pkt_end),
        .full           (full),
        .gen_idle       (gen_idle),
        .range_info     (range_info),
        .range_info_new (range_info_new),
        .err            (err)
    );

    range_info_loader #(.WORD_MAX_LEN(6), .RANGES_MAX(8)) u_dut6 (
        .CLK            (CLK),
        .rst_n          (rst6_n),
        .din            (din6),
        .wr_en          (wr_en6),
        .pkt_end        (pkt_end6),
        .full           (full6),
        .gen_idle       (gen_idle6),
        .range_info     (range_info6),
        .range_info_new (range_info_new6),
        .err            (err6)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic send(input logic [7:0] b, input logic last);
        din = b; wr_en = 1'b1; pkt_end = last;
        @(negedge CLK);
        wr_en = 1'b0; pkt_end = 1'b0;
    endtask

    task automatic send6(input logic [7:0] b, input logic last);
        din6 = b; wr_en6 = 1'b1; pkt_end6 = last;
        @(negedge CLK);
        wr_en6 = 1'b0; pkt_end6 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rst6_n = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        rst_n = 1'b1; rst6_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst6_n = 1'b0;
        @(negedge CLK);
        vectors++;
        if (range_info !== 32'h0 || full !== 1'b0 || range_info_new !== 1'b0 || err !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_state: range_info=%h full=%b new=%b err=%b, need 0/0/0/000", range_info, full, range_info_new, err);
        end
        @(negedge CLK);
        rst_n = 1'b1; rst6_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_full_load();
        gen_idle = 1'b1;
        for (int k = 0; k < 8; k++) send(8'(8 + k), k == 7);
        vectors++;
        if (range_info_new !== 1'b0 || full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_load_ready: new=%b full=%b, need 0/1", range_info_new, full);
        end
        @(negedge CLK);
        vectors++;
        if (range_info_new !== 1'b1 || range_info !== 32'hFEDCBA98) begin
            miscompares++;
            $display("FAIL full_load_pulse: new=%b range_info=%h, need 1/FEDCBA98", range_info_new, range_info);
        end
        vectors++;
        if (err !== 3'b000 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL full_load_err: err=%b full=%b, need 000/0", err, full);
        end
        @(negedge CLK);
        vectors++;
        if (range_info_new !== 1'b0) begin
            miscompares++;
            $display("FAIL full_load_single_pulse: new=%b, need 0", range_info_new);
        end
    endtask

    task automatic test_gen_busy();
        gen_idle = 1'b0;
        send(8'h08, 1'b0);
        send(8'h0B, 1'b1);
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (full !== 1'b1 || range_info_new !== 1'b0 || range_info !== 32'hFEDCBA98) begin
                miscompares++;
                $display("FAIL gen_busy_hold[%0d]: full=%b new=%b range_info=%h, need 1/0/FEDCBA98", c, full, range_info_new, range_info);
            end
            @(negedge CLK);
        end
        gen_idle = 1'b1;
        @(negedge CLK);
        vectors++;
        if (range_info_new !== 1'b1 || range_info !== 32'h000000B8) begin
            miscompares++;
            $display("FAIL gen_busy_release: new=%b range_info=%h, need 1/000000B8", range_info_new, range_info);
        end
        @(negedge CLK);
    endtask

    task automatic test_order_err();
        send(8'h00, 1'b0);
        send(8'h09, 1'b1);
        vectors++;
        if (err !== 3'b100 || full !== 1'b1) begin
            miscompares++;
            $display("FAIL order_err: err=%b full=%b, need 100/1", err, full);
        end
        send(8'h08, 1'b1);
        repeat (3) @(negedge CLK);
        vectors++;
        if (err !== 3'b100 || full !== 1'b1 || range_info !== 32'h000000B8 || range_info_new !== 1'b0) begin
            miscompares++;
            $display("FAIL order_err_stuck: err=%b full=%b range_info=%h new=%b, need 100/1/000000B8/0", err, full, range_info, range_info_new);
        end
    endtask

    task automatic test_pos_err();
        do_reset();
        send(8'h10, 1'b1);
        vectors++;
        if (err !== 3'b010 || full !== 1'b1) begin
            miscompares++;
            $display("FAIL pos_err_upper: err=%b full=%b, need 010/1", err, full);
        end
        gen_idle6 = 1'b1;
        send6(8'h0D, 1'b1);
        @(negedge CLK);
        vectors++;
        if (range_info6 !== 32'h0000000D || err6 !== 3'b000) begin
            miscompares++;
            $display("FAIL pos_edge_legal: range_info=%h err=%b, need 0000000D/000", range_info6, err6);
        end
        @(negedge CLK);
        send6(8'h0E, 1'b1);
        vectors++;
        if (err6 !== 3'b010 || full6 !== 1'b1) begin
            miscompares++;
            $display("FAIL pos_err_wml6: err=%b full=%b, need 010/1", err6, full6);
        end
    endtask

    task automatic test_len_err();
        do_reset();
        for (int k = 0; k < 7; k++) send(8'h08, 1'b0);
        vectors++;
        if (err !== 3'b000 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL len_seven_ok: err=%b full=%b, need 000/0", err, full);
        end
        send(8'h08, 1'b0);
        vectors++;
        if (err !== 3'b001 || full !== 1'b1 || range_info !== 32'h0) begin
            miscompares++;
            $display("FAIL len_err: err=%b full=%b range_info=%h, need 001/1/00000000", err, full, range_info);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        gen_idle = 1'b1;
        send(8'h09, 1'b1);
        @(negedge CLK);
        vectors++;
        if (range_info !== 32'h00000009 || range_info_new !== 1'b1) begin
            miscompares++;
            $display("FAIL single_byte_pkt: range_info=%h new=%b, need 00000009/1", range_info, range_info_new);
        end
        @(negedge CLK);
        send(8'h08, 1'b0);
        send(8'h08, 1'b0);
        send(8'h08, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (range_info !== 32'h0 || full !== 1'b0 || err !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid_packet: range_info=%h full=%b err=%b, need 0/0/000", range_info, full, err);
        end
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < 8; k++) send(8'(15 - k), k == 7);
        @(negedge CLK);
        vectors++;
        if (range_info !== 32'h89ABCDEF || range_info_new !== 1'b1 || err !== 3'b000) begin
            miscompares++;
            $display("FAIL reload_after_reset: range_info=%h new=%b err=%b, need 89ABCDEF/1/000", range_info, range_info_new, err);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; rst6_n = 1'b0;
        din = '0; wr_en = 1'b0; pkt_end = 1'b0; gen_idle = 1'b0;
        din6 = '0; wr_en6 = 1'b0; pkt_end6 = 1'b0; gen_idle6 = 1'b0;
        @(negedge CLK);
        test_reset();
        test_full_load();
        test_gen_busy();
        test_order_err();
        test_pos_err();
        test_len_err();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
